qoi_pingpong_buffer: RTL and testbench

- Parametrised double-buffered (ping-pong) memory between host side A (6502 bus) and engine side B (QOI codec).
- Input path: two banks filled by A and drained by B.
- Output path: two banks filled by B and drained by A.
- Bank ownership is tracked internally via commit/release handshakes, replacing the single external select and one-shot flag, so the host fills bank N+1 while the engine processes bank N.

---
 rtl/qoi_pingpong_buffer.sv | 170 +++++++++++++++++
 tb/tb_qoi_pingpong_buffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/qoi_pingpong_buffer.sv
// Ping-pong bank buffer between the 6502 host (side A) and the QOI engine (side B).
// Each direction owns two banks whose ownership moves via commit/release handshakes.

module qoi_pp_path #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int AUTO_COMMIT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              commit,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              rel,
   output logic              ready,
   output logic              valid,
   output logic              overflow,
   output logic              underflow
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [2][DEPTH];

   logic [1:0]        full_q, full_d;
   logic              wp_q, wp_d;
   logic              rp_q, rp_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              wr_ok, do_commit, do_release, last_addr;

   assign ready     = !full_q[wp_q];
   assign valid     = full_q[rp_q];
   assign rd_data   = rd_data_q;
   assign overflow  = wr_en & !ready;
   assign underflow = rd_en & !valid;

   // A legal commit and release can never hit the same bank, so applying both is safe.
   always_comb begin
      wr_ok      = wr_en & ready;
      last_addr  = (wr_addr == {ADDR_W{1'b1}});
      do_commit  = ready & (commit | ((AUTO_COMMIT != 0) & wr_ok & last_addr));
      do_release = rel & valid;
      full_d     = full_q;
      if (do_commit)
         full_d[wp_q] = 1'b1;
      if (do_release)
         full_d[rp_q] = 1'b0;
      wp_d = wp_q ^ do_commit;
      rp_d = rp_q ^ do_release;
      rd_data_d = rd_data_q;
      if (rd_en)
         rd_data_d = valid ? mem[rp_q][rd_addr] : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full_q    <= '0;
         wp_q      <= 1'b0;
         rp_q      <= 1'b0;
         rd_data_q <= '0;
      end else begin
         full_q    <= full_d;
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Bank storage carries no reset; contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wp_q][wr_addr] <= wr_data;
   end

endmodule

module qoi_pingpong_buffer #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int AUTO_COMMIT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data_i,
   output logic [DATA_W-1:0] a_data_o,
   input  logic              a_cs,
   input  logic              a_we,
   input  logic              a_commit,
   input  logic              a_release,
   output logic              a_in_ready,
   output logic              a_out_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data_i,
   output logic [DATA_W-1:0] b_data_o,
   input  logic              b_cs,
   input  logic              b_we,
   input  logic              b_commit,
   input  logic              b_release,
   output logic              b_in_valid,
   output logic              b_out_ready,
   input  logic              err_clr,
   output logic              err_overflow,
   output logic              err_underflow
);

   logic in_ovf, in_udf, out_ovf, out_udf;
   logic err_overflow_q, err_overflow_d;
   logic err_underflow_q, err_underflow_d;

   // Input path: host produces, engine consumes.
   qoi_pp_path #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AUTO_COMMIT(AUTO_COMMIT)) u_in (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (a_cs & a_we),
      .wr_addr   (a_addr),
      .wr_data   (a_data_i),
      .commit    (a_commit),
      .rd_en     (b_cs & !b_we),
      .rd_addr   (b_addr),
      .rd_data   (b_data_o),
      .rel       (b_release),
      .ready     (a_in_ready),
      .valid     (b_in_valid),
      .overflow  (in_ovf),
      .underflow (in_udf)
   );

   // Output path: engine produces, host consumes.
   qoi_pp_path #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AUTO_COMMIT(AUTO_COMMIT)) u_out (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (b_cs & b_we),
      .wr_addr   (b_addr),
      .wr_data   (b_data_i),
      .commit    (b_commit),
      .rd_en     (a_cs & !a_we),
      .rd_addr   (a_addr),
      .rd_data   (a_data_o),
      .rel       (a_release),
      .ready     (b_out_ready),
      .valid     (a_out_valid),
      .overflow  (out_ovf),
      .underflow (out_udf)
   );

   // Clearing wins over an error raised in the same cycle.
   always_comb begin
      err_overflow_d  = err_clr ? 1'b0 : (err_overflow_q | in_ovf | out_ovf);
      err_underflow_d = err_clr ? 1'b0 : (err_underflow_q | in_udf | out_udf);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_overflow_q  <= 1'b0;
         err_underflow_q <= 1'b0;
      end else begin
         err_overflow_q  <= err_overflow_d;
         err_underflow_q <= err_underflow_d;
      end
   end

   assign err_overflow  = err_overflow_q;
   assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_qoi_pingpong_buffer.sv
// Directed bench for qoi_pingpong_buffer: bank handoff on both paths, errors and async reset.

module tb_qoi_pingpong_buffer;

   logic       clk;
   logic       rst;
   logic [7:0] a_addr, a_data_i, a_data_o;
   logic       a_cs, a_we, a_commit, a_release, a_in_ready, a_out_valid;
   logic [7:0] b_addr, b_data_i, b_data_o;
   logic       b_cs, b_we, b_commit, b_release, b_in_valid, b_out_ready;
   logic       err_clr, err_overflow, err_underflow;

   int total = 0;
   int bad   = 0;

   qoi_pingpong_buffer #(.DATA_W(8), .ADDR_W(8), .AUTO_COMMIT(1)) dut (
      .clk           (clk),
      .rst           (rst),
      .a_addr        (a_addr),
      .a_data_i      (a_data_i),
      .a_data_o      (a_data_o),
      .a_cs          (a_cs),
      .a_we          (a_we),
      .a_commit      (a_commit),
      .a_release     (a_release),
      .a_in_ready    (a_in_ready),
      .a_out_valid   (a_out_valid),
      .b_addr        (b_addr),
      .b_data_i      (b_data_i),
      .b_data_o      (b_data_o),
      .b_cs          (b_cs),
      .b_we          (b_we),
      .b_commit      (b_commit),
      .b_release     (b_release),
      .b_in_valid    (b_in_valid),
      .b_out_ready   (b_out_ready),
      .err_clr       (err_clr),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle 1 ns past it before anything is sampled.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      a_cs = 0; a_we = 0; a_commit = 0; a_release = 0; a_addr = 0; a_data_i = 0;
      b_cs = 0; b_we = 0; b_commit = 0; b_release = 0; b_addr = 0; b_data_i = 0;
      err_clr = 0;
   endtask

   initial begin
      rst = 0;
      idleInputs();
      #12;
      checkOutput("rst_a_in_ready", a_in_ready, 1);
      checkOutput("rst_b_out_ready", b_out_ready, 1);
      checkOutput("rst_b_in_valid", b_in_valid, 0);
      checkOutput("rst_a_out_valid", a_out_valid, 0);
      checkOutput("rst_data", {a_data_o, b_data_o}, 0);
      checkOutput("rst_errs", {err_overflow, err_underflow}, 0);
      rst = 1;
      applyStimulus();

      // Fill input bank 0; the addr-255 write auto-commits it.
      for (int i = 0; i < 256; i++) begin
         a_cs = 1; a_we = 1; a_addr = 8'(i); a_data_i = 8'(i) ^ 8'h5A;
         applyStimulus();
         if (i == 254) checkOutput("fill0_not_valid_early", b_in_valid, 0);
      end
      idleInputs();
      checkOutput("fill0_b_in_valid", b_in_valid, 1);
      checkOutput("fill0_a_in_ready", a_in_ready, 1);

      b_cs = 1; b_we = 0; b_addr = 8'd7;
      applyStimulus();
      idleInputs();
      checkOutput("b_read7", b_data_o, 8'h5D);
      applyStimulus();
      checkOutput("b_read7_hold", b_data_o, 8'h5D);

      // Partially fill bank 1 and commit it explicitly.
      for (int i = 0; i < 16; i++) begin
         a_cs = 1; a_we = 1; a_addr = 8'(i); a_data_i = 8'(i) ^ 8'hA5;
         applyStimulus();
      end
      idleInputs();
      a_commit = 1;
      applyStimulus();
      idleInputs();
      checkOutput("both_full_a_in_ready", a_in_ready, 0);
      a_cs = 1; a_we = 1; a_addr = 8'd7; a_data_i = 8'hFF;
      applyStimulus();
      idleInputs();
      checkOutput("ovf_set", err_overflow, 1);
      b_cs = 1; b_we = 0; b_addr = 8'd7;
      applyStimulus();
      idleInputs();
      checkOutput("bank0_unchanged", b_data_o, 8'h5D);

      b_release = 1; a_commit = 1;
      applyStimulus();
      idleInputs();
      checkOutput("rel_a_in_ready", a_in_ready, 1);
      checkOutput("rel_b_in_valid", b_in_valid, 1);
      b_cs = 1; b_we = 0; b_addr = 8'd7;
      applyStimulus();
      idleInputs();
      checkOutput("bank1_read7", b_data_o, 8'hA2);
      b_cs = 1; b_we = 0; b_addr = 8'd3;
      applyStimulus();
      idleInputs();
      checkOutput("bank1_read3", b_data_o, 8'hA6);
      err_clr = 1;
      applyStimulus();
      idleInputs();
      checkOutput("ovf_cleared", err_overflow, 0);

      // Output path: engine writes then commits bank 0.
      b_cs = 1; b_we = 1; b_addr = 8'd3; b_data_i = 8'hC4;
      applyStimulus();
      idleInputs();
      b_commit = 1;
      applyStimulus();
      idleInputs();
      checkOutput("out_a_out_valid", a_out_valid, 1);
      checkOutput("out_b_out_ready", b_out_ready, 1);
      a_cs = 1; a_we = 0; a_addr = 8'd3;
      applyStimulus();
      idleInputs();
      checkOutput("a_read3", a_data_o, 8'hC4);

      // Write and commit in one cycle lands in bank 1; release bank 0 alongside.
      b_cs = 1; b_we = 1; b_addr = 8'd9; b_data_i = 8'h3C; b_commit = 1; a_release = 1;
      applyStimulus();
      idleInputs();
      checkOutput("wc_a_out_valid", a_out_valid, 1);
      a_cs = 1; a_we = 0; a_addr = 8'd9;
      applyStimulus();
      idleInputs();
      checkOutput("a_read9_bank1", a_data_o, 8'h3C);
      a_release = 1;
      applyStimulus();
      idleInputs();
      checkOutput("rel_a_out_valid", a_out_valid, 0);

      a_cs = 1; a_we = 0; a_addr = 8'd9;
      applyStimulus();
      idleInputs();
      checkOutput("udf_data_zero", a_data_o, 0);
      checkOutput("udf_set", err_underflow, 1);
      err_clr = 1;
      applyStimulus();
      idleInputs();
      checkOutput("udf_cleared", err_underflow, 0);
      err_clr = 1; a_cs = 1; a_we = 0;
      applyStimulus();
      idleInputs();
      checkOutput("clr_priority", err_underflow, 0);

      // Build up busy state, then drop reset between edges.
      a_commit = 1;
      applyStimulus();
      idleInputs();
      checkOutput("pre_rst_a_in_ready", a_in_ready, 0);
      a_cs = 1; a_we = 1; a_addr = 8'd1; a_data_i = 8'h11;
      b_cs = 1; b_we = 1; b_addr = 8'd1; b_data_i = 8'h22; b_commit = 1;
      applyStimulus();
      idleInputs();
      checkOutput("pre_rst_ovf", err_overflow, 1);
      checkOutput("pre_rst_a_out_valid", a_out_valid, 1);
      #3;
      rst = 0;
      #1;
      checkOutput("async_a_in_ready", a_in_ready, 1);
      checkOutput("async_b_in_valid", b_in_valid, 0);
      checkOutput("async_a_out_valid", a_out_valid, 0);
      checkOutput("async_errs", {err_overflow, err_underflow}, 0);
      checkOutput("async_data", {a_data_o, b_data_o}, 0);
      #10;
      rst = 1;
      applyStimulus();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
